// File: rtl/multicycle_alu.sv
// multicycle_alu: add/sub complete in one cycle; unsigned shift-add multiply and
// restoring divide iterate one bit per cycle. Valid/ready handshake on both sides.
// Revision: 1.0
`default_nettype none

module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_OutHi,
  output logic             CarryOut,
  output logic             DivByZero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  logic             accept;
  logic             handoff;
  logic             is_iter_op;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   addsub;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  assign accept     = in_valid && in_ready;
  assign handoff    = out_valid && out_ready;
  assign is_iter_op = (ALU_Sel == OP_MUL) || (ALU_Sel == OP_DIV);

  // Subtraction is A + ~B + 1, so the carry out is the "no borrow" flag.
  assign is_sub = (ALU_Sel == OP_SUB);
  assign b_eff  = is_sub ? ~B : B;
  assign addsub = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = is_iter_op ? CALC : DONE;
        end
      end
      CALC: begin
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (handoff) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // acc_hi:acc_lo is the product (mul) or remainder:quotient (div) in progress.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, op_b});
  assign div_diff  = div_shift[WIDTH-1:0] - op_b;

  // With B == 0 every trial subtraction succeeds, so the quotient saturates to
  // all ones and the dividend bits shift straight into the remainder.
  always_comb begin
    hi_nxt = acc_hi;
    lo_nxt = acc_lo;
    if (op_sel == OP_DIV) begin
      hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      ALU_Out   <= '0;
      ALU_OutHi <= '0;
      CarryOut  <= 1'b0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      op_a   <= A;
      op_b   <= B;
      op_sel <= ALU_Sel;
      acc_hi <= '0;
      acc_lo <= (ALU_Sel == OP_DIV) ? A : B;
      cnt    <= is_iter_op ? CNT_LOAD : '0;
      if (!is_iter_op) begin
        ALU_Out   <= addsub[WIDTH-1:0];
        ALU_OutHi <= '0;
        CarryOut  <= addsub[WIDTH];
        DivByZero <= 1'b0;
      end
    end else if (state == CALC) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        ALU_Out   <= lo_nxt;
        ALU_OutHi <= hi_nxt;
        CarryOut  <= (op_sel == OP_MUL) && (|hi_nxt);
        DivByZero <= (op_sel == OP_DIV) && (op_b == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=32.
// Revision: 1.0
`default_nettype none

module tb_multicycle_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic [WIDTH-1:0] ALU_OutHi;
  logic             CarryOut;
  logic             DivByZero;
  logic             out_valid;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALU_Out   (ALU_Out),
    .ALU_OutHi (ALU_OutHi),
    .CarryOut  (CarryOut),
    .DivByZero (DivByZero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE, measure latency, optionally hold backpressure, then retire it.
  task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_out,
                        input logic [31:0] exp_hi, input logic exp_c, input logic exp_dz,
                        input int hold);
    int lat;
    A = a; B = b; ALU_Sel = sel; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALU_Sel = 4'b0011;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " out"}, 64'(ALU_Out), 64'(exp_out));
    check_eq({tag, " hi"}, 64'(ALU_OutHi), 64'(exp_hi));
    check_eq({tag, " carry"}, 64'(CarryOut), 64'(exp_c));
    check_eq({tag, " divzero"}, 64'(DivByZero), 64'(exp_dz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check_eq({tag, " hold out"}, 64'(ALU_Out), 64'(exp_out));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int sent;
    int got;
    int ov;
    rst_n = 1'b0; A = '0; B = '0; ALU_Sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset out", 64'(ALU_Out), 64'd0);
    check_eq("reset hi", 64'(ALU_OutHi), 64'd0);
    rst_n = 1'b1;

    run_op("add wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    run_op("sub borrow", 4'b0001, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 0);
    run_op("sub noborrow", 4'b0001, 32'd7, 32'd5, 1, 32'd2, 32'h0, 1'b1, 1'b0, 0);
    run_op("add alias op", 4'b1010, 32'd2, 32'd3, 1, 32'd5, 32'h0, 1'b0, 1'b0, 0);
    run_op("mul max", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
    run_op("mul small", 4'b0010, 32'd12345, 32'd6789, 33, 32'd83810205, 32'h0, 1'b0, 1'b0, 0);
    run_op("div", 4'b0011, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0, 0);
    run_op("add backpressure", 4'b0000, 32'h1111_1111, 32'h2222_2222, 1, 32'h3333_3333, 32'h0, 1'b0, 1'b0, 10);
    run_op("div zero", 4'b0011, 32'd100, 32'd0, 33, 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b1, 0);

    // Abort a multiply partway through with reset.
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; ALU_Sel = 4'b0010; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("abort out_valid", 64'(out_valid), 64'd0);
    check_eq("abort in_ready", 64'(in_ready), 64'd1);
    check_eq("abort out", 64'(ALU_Out), 64'd0);
    check_eq("abort hi", 64'(ALU_OutHi), 64'd0);
    check_eq("abort flags", 64'({CarryOut, DivByZero}), 64'd0);
    ov = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) ov++;
    end
    check_eq("abort no result", 64'(ov), 64'd0);
    run_op("add after abort", 4'b0000, 32'd3, 32'd4, 1, 32'd7, 32'h0, 1'b0, 1'b0, 0);

    // Streaming adds with in_valid and out_ready held high.
    sent = 0;
    got  = 0;
    ALU_Sel = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        A = 32'(100 + sent);
        B = 32'd1;
        sent++;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        check_eq("stream result", 64'(ALU_Out), 64'(101 + got));
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("stream results", 64'(got), 64'd10);
    check_eq("stream accepts", 64'(sent), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width (legal range 4..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on the clk rising edge.
REQ-005 A  input  WIDTH  operand A (dividend or multiplicand).
REQ-006 B  input  WIDTH  operand B (divisor or multiplier).
REQ-007 ALU_Sel  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div; all other codes act as add.
REQ-008 in_valid  input  1  the A, B and ALU_Sel inputs are valid.
REQ-009 in_ready  output  1  the block can accept an operation.
REQ-010 ALU_Out  output  WIDTH  primary result (sum, difference, product low half, or quotient).
REQ-011 ALU_OutHi  output  WIDTH  secondary result (product high half for mul, remainder for div, 0 otherwise).
REQ-012 CarryOut  output  1  carry/status flag, defined per opcode below.
REQ-013 DivByZero  output  1  the div operation had B == 0.
REQ-014 out_valid  output  1  the result outputs are valid.
REQ-015 out_ready  input  1  the consumer accepts the result.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 An operation SHALL be accepted only on a clock edge where in_valid && in_ready; A, B and ALU_Sel SHALL be captured into internal registers at that edge.
REQ-018 Input changes SHALL have no effect outside the accept edge.
REQ-019 For add and sub, the FSM SHALL go from IDLE to DONE on accept, with the result registered at that edge, so out_valid rises 1 cycle after accept.
REQ-020 Add SHALL produce ALU_Out = (A+B) mod 2^WIDTH and CarryOut = bit WIDTH of the (WIDTH+1)-bit sum.
REQ-021 Sub SHALL produce ALU_Out = (A-B) mod 2^WIDTH and CarryOut = 1 when A >= B (no borrow), computed as A + ~B + 1.
REQ-022 For mul and div, the FSM SHALL go from IDLE to CALC on accept and perform exactly WIDTH iterations.
REQ-023 After those WIDTH iterations the FSM SHALL enter DONE, so out_valid rises WIDTH+1 cycles after accept.
REQ-024 Mul SHALL be unsigned shift-add, one multiplier bit per cycle, LSB first.
REQ-025 Mul SHALL produce {ALU_OutHi, ALU_Out} = the 2*WIDTH-bit product, with CarryOut = |ALU_OutHi (overflow of the low half).
REQ-026 Div SHALL be unsigned restoring division, one quotient bit per cycle, MSB first, producing ALU_Out = quotient, ALU_OutHi = remainder and CarryOut = 0.
REQ-027 Div by zero SHALL still take WIDTH+1 cycles and SHALL produce ALU_Out = all ones, ALU_OutHi = A and DivByZero = 1.
REQ-028 DivByZero SHALL be 0 for every other operation.
REQ-029 The iteration counter SHALL load WIDTH on entry to CALC and decrement once per CALC cycle; the FSM SHALL enter DONE on the cycle the counter reaches 1.
REQ-030 All result outputs SHALL stay stable for the whole DONE state until out_valid && out_ready.
REQ-031 On the edge where out_valid && out_ready, the FSM SHALL go from DONE to IDLE; a new accept is then possible on the next edge (no same-cycle accept).
REQ-032 Results SHALL be held indefinitely under backpressure (out_ready low); in_ready SHALL stay 0 during CALC and DONE.
REQ-033 Opcodes 0100..1111 SHALL follow the add timing and result.

Reset
REQ-034 When rst_n = 0 at a clk edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-035 When rst_n = 0 at a clk edge, ALU_Out, ALU_OutHi, CarryOut, DivByZero and out_valid SHALL go to 0 and in_ready SHALL go to 1 on the following cycle.
REQ-036 Reset during CALC or DONE SHALL abort the operation with no result delivered; the first accept after reset SHALL start a fresh operation.
REQ-037 Reset SHALL take priority over an accept or handshake on the same edge.

Verification (WIDTH=32)
REQ-038 add A=FFFFFFFF, B=00000001 -> 1 cycle after accept, out_valid=1, ALU_Out=00000000, CarryOut=1; sub A=5, B=7 -> ALU_Out=FFFFFFFE, CarryOut=0.
REQ-039 mul A=FFFFFFFF, B=FFFFFFFF -> out_valid exactly 33 cycles after accept, ALU_Out=00000001, ALU_OutHi=FFFFFFFE, CarryOut=1.
REQ-040 div A=100, B=7 -> after 33 cycles, ALU_Out=14, ALU_OutHi=2, DivByZero=0; div A=100, B=0 -> ALU_Out=FFFFFFFF, ALU_OutHi=100, DivByZero=1.
REQ-041 Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> outputs stable and in_ready=0 throughout; raise out_ready -> in_ready=1 on the next cycle.
REQ-042 Assert rst_n=0 at cycle 10 of a mul -> out_valid stays 0 and all outputs are 0; a following add 3+4 returns 7 after 1 cycle.
REQ-043 Hold in_valid=1 continuously with out_ready=1 -> accepts occur only in IDLE, add throughput is 1 result per 2 cycles, and no operation is lost or duplicated.
